// File: rtl/mio_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_encode_def (package)
//  Description : Shared encodings for the MIO load/store unit: DMType codes,
//                LSU response error codes and FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_encode_def;

    // Data-memory access type (DMType) encodings
    localparam logic [2:0] dm_word              = 3'b000;
    localparam logic [2:0] dm_halfword          = 3'b001;
    localparam logic [2:0] dm_halfword_unsigned = 3'b010;
    localparam logic [2:0] dm_byte              = 3'b011;
    localparam logic [2:0] dm_byte_unsigned     = 3'b100;

    // Response error codes
    localparam logic [1:0] LSU_ERR_OK       = 2'b00;
    localparam logic [1:0] LSU_ERR_MISALIGN = 2'b01;
    localparam logic [1:0] LSU_ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] LSU_ERR_ILLEGAL  = 2'b11;

    // LSU controller states
    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUS  = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/mio_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Combinational lane logic for the LSU: byte enables, store
//                lane replication, load lane extraction/extension and
//                alignment / type legality checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import ctrl_encode_def::*;
(
    input  logic [2:0]  dmtype,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misaligned,
    output logic        illegal
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    // Lanes of the read word addressed by the low address bits
    assign w_half = addr[1] ? rdata[31:16] : rdata[15:0];
    assign w_byte = rdata[{addr, 3'b000} +: 8];

    // Decode access size into enables, replicated store data and extended load data
    always_comb begin
        be         = 4'b0000;
        wdata_rep  = 32'h0000_0000;
        rdata_ext  = 32'h0000_0000;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (dmtype)
            dm_word: begin
                be         = 4'b1111;
                wdata_rep  = wdata;
                rdata_ext  = rdata;
                misaligned = (addr != 2'b00);
            end
            dm_halfword, dm_halfword_unsigned: begin
                be         = addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep  = {2{wdata[15:0]}};
                rdata_ext  = (dmtype == dm_halfword) ? {{16{w_half[15]}}, w_half}
                                                     : {16'h0000, w_half};
                misaligned = addr[0];
            end
            dm_byte, dm_byte_unsigned: begin
                be         = 4'b0001 << addr;
                wdata_rep  = {4{wdata[7:0]}};
                rdata_ext  = (dmtype == dm_byte) ? {{24{w_byte[7]}}, w_byte}
                                                 : {24'h000000, w_byte};
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mio_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mio_lsu
//  Description : Multi-cycle load/store unit bridging the core data port to
//                the MIO bus with a request/response handshake, stall
//                generation, lane handling and error/timeout reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module mio_lsu
    import ctrl_encode_def::*;
#(
    parameter int AW      = 32,
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [2:0]    req_dmtype,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          req_ready,
    output logic          stall,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic [1:0]    rsp_err,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [3:0]    bus_be,
    output logic [31:0]   bus_wdata,
    input  logic [31:0]   bus_rdata,
    input  logic          bus_ready
);

    localparam bit            c_TO_EN       = (TIMEOUT != 0);
    localparam int            c_TO_LAST_INT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CW-1:0] c_CNT_LAST    = c_TO_LAST_INT[CW-1:0];

    lsu_state_e    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_we;
    logic [2:0]    r_dmtype;
    logic [AW-1:0] r_addr;
    logic [3:0]    r_be;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rsp_rdata;
    logic [1:0]    r_rsp_err;

    logic          w_idle;
    logic [2:0]    w_al_dmtype;
    logic [1:0]    w_al_addr;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata_rep;
    logic [31:0]   w_rdata_ext;
    logic          w_misaligned;
    logic          w_illegal;

    // In IDLE the lane logic checks the incoming request; afterwards it works
    // on the captured request so load extraction uses the accepted type/offset.
    assign w_idle      = (r_state == LSU_IDLE);
    assign w_al_dmtype = w_idle ? req_dmtype    : r_dmtype;
    assign w_al_addr   = w_idle ? req_addr[1:0] : r_addr[1:0];

    lsu_align u_align (
        .dmtype     (w_al_dmtype),
        .addr       (w_al_addr),
        .wdata      (req_wdata),
        .rdata      (bus_rdata),
        .be         (w_be),
        .wdata_rep  (w_wdata_rep),
        .rdata_ext  (w_rdata_ext),
        .misaligned (w_misaligned),
        .illegal    (w_illegal)
    );

    // Request capture, bus wait/timeout sequencing and registered response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= LSU_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_dmtype    <= 3'b000;
            r_addr      <= '0;
            r_be        <= 4'b0000;
            r_wdata     <= 32'h0000_0000;
            r_rsp_rdata <= 32'h0000_0000;
            r_rsp_err   <= LSU_ERR_OK;
        end else begin
            case (r_state)
                LSU_IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_dmtype <= req_dmtype;
                        r_addr   <= req_addr;
                        r_be     <= w_be;
                        r_wdata  <= w_wdata_rep;
                        r_cnt    <= '0;
                        if (w_illegal) begin
                            r_state   <= LSU_RESP;
                            r_rsp_err <= LSU_ERR_ILLEGAL;
                        end else if (w_misaligned) begin
                            r_state   <= LSU_RESP;
                            r_rsp_err <= LSU_ERR_MISALIGN;
                        end else begin
                            r_state <= LSU_BUS;
                        end
                    end
                end
                LSU_BUS: begin
                    if (bus_ready) begin
                        r_state     <= LSU_RESP;
                        r_rsp_err   <= LSU_ERR_OK;
                        r_rsp_rdata <= r_we ? 32'h0000_0000 : w_rdata_ext;
                    end else if (c_TO_EN && (r_cnt == c_CNT_LAST)) begin
                        r_state     <= LSU_RESP;
                        r_rsp_err   <= LSU_ERR_TIMEOUT;
                        r_rsp_rdata <= 32'h0000_0000;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                LSU_RESP: begin
                    // Response fields read as zero outside the pulse cycle
                    r_state     <= LSU_IDLE;
                    r_rsp_rdata <= 32'h0000_0000;
                    r_rsp_err   <= LSU_ERR_OK;
                end
                default: begin
                    r_state <= LSU_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (r_state == LSU_IDLE);
    assign rsp_valid = (r_state == LSU_RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    // Stall also drops while reset is held so the core is released at once
    assign stall     = req_valid & ~rsp_valid & ~reset;

    // Bus side is quiet unless an access is in flight
    assign bus_req   = (r_state == LSU_BUS);
    assign bus_we    = bus_req & r_we;
    assign bus_addr  = bus_req ? {r_addr[AW-1:2], 2'b00} : '0;
    assign bus_be    = bus_req ? r_be : 4'b0000;
    assign bus_wdata = bus_req ? r_wdata : 32'h0000_0000;

endmodule
`default_nettype wire

// File: doc/mio_lsu.md
Name: mio_lsu

Overview:
Multi-cycle load/store unit between the core's data port and the MIO bus. It replaces the core's direct single-cycle `Data_in` / `Data_out` / `mem_w` path with a request/response handshake.
- Stalls the core while the bus is not ready (`bus_ready`).
- Generates byte enables and store-lane replication from DMType.
- Extracts and extends load data.
- Reports misaligned, illegal-type and timeout errors.
- Parametrised in address width and timeout depth.

Parameters:
- AW, 32: address width in bits (>= 2).
- TIMEOUT, 255: bus wait cycles before abort; 0 disables timeout.
- CW, 8: timeout counter width; TIMEOUT must be < 2^CW.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  core has a load/store this cycle; held stable until rsp_valid
- req_we  in  1  1 = store, 0 = load
- req_dmtype  in  3  DMType of the access
- req_addr  in  AW  byte address (ALU output)
- req_wdata  in  32  store data (rs2 value)
- req_ready  out  1  LSU idle; request accepted this cycle if req_valid
- stall  out  1  freeze PC/pipeline; equals req_valid & ~rsp_valid
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal DMType
- bus_req  out  1  bus access active (CPU_MIO)
- bus_we  out  1  bus write
- bus_addr  out  AW  word-aligned address ({addr[AW-1:2], 2'b00})
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_rdata  in  32  bus read data
- bus_ready  in  1  bus completes the access this cycle (MIO_ready)

Behaviour:
- Reset values (asynchronous): state = IDLE, counter = 0, captured registers = 0. All outputs are 0 except req_ready = 1.
- Reset asserted mid-access: bus_req drops immediately and no rsp_valid is issued.

DMType encoding:
- 000 word
- 001 half
- 010 half unsigned
- 011 byte
- 100 byte unsigned
- 101–111 illegal

State machine:
- States are IDLE, BUS, RESP.
- req_ready = (state == IDLE).
- IDLE with req_valid: capture we, dmtype, addr, wdata, then check the request.
  - Illegal DMType → RESP, err = 11.
  - Misaligned (half with addr[0] = 1, word with addr[1:0] != 0) → RESP, err = 01.
  - Otherwise → BUS, counter = 0.
- Illegal-type and misaligned requests never assert bus_req.
- BUS: bus_req = 1; bus_we, bus_addr, bus_be, bus_wdata are driven from registered capture and stay stable while waiting.
  - bus_ready = 1: latch rdata, → RESP with err = 00.
  - Else if TIMEOUT != 0 and counter == TIMEOUT-1: → RESP with err = 10; bus_req deasserts.
  - Else counter + 1.
- RESP: rsp_valid = 1 for exactly one cycle, → IDLE. rsp_rdata and rsp_err are registered.
- bus_ready is ignored outside BUS.

Latency:
- Zero-wait-state bus: accept at cycle N, bus_req at N+1, rsp_valid at N+2.
- Each bus wait cycle adds 1.
- Errors detected in IDLE: rsp_valid at N+1.

Byte enables (by captured addr[1:0]):
- word: 1111
- half: 0011 or 1100, by addr[1]
- byte: 0001 << addr[1:0]
- Loads drive the same bus_be.

Store data:
- word: wdata
- half: {2{wdata[15:0]}}
- byte: {4{wdata[7:0]}}

Load data:
- Lane selected by addr[1:0].
- Sign-extended for 001 and 011; zero-extended for 010 and 100.
- rsp_rdata = 0 on a store or when rsp_err != 00.

Stall behaviour:
- Core holds req_valid until rsp_valid; stall is low in the rsp_valid cycle.
- A new request cannot be accepted in RESP; it is accepted in the following IDLE cycle.

Decomposition:
- Shared package `ctrl_encode_def`:
  - `dm_*` DMType constants.
  - `LSU_ERR_*` codes (OK/MISALIGN/TIMEOUT/ILLEGAL).
  - State encodings.
- One sub-module, `lsu_align` (combinational): inputs dmtype, addr[1:0], wdata, rdata; outputs be, wdata_rep, rdata_ext, misaligned, illegal.
- The FSM and counter live in mio_lsu.

Test Plan:
- Load word 0x00000010, bus_ready tied 1, bus_rdata 0xDEADBEEF → bus_req at N+1, bus_be = 1111; rsp_valid at N+2, rsp_rdata = 0xDEADBEEF, rsp_err = 00; stall high for cycles N and N+1 only.
- LB at 0x13, bus_rdata 0x80123456 → bus_be = 1000, rsp_rdata = 0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x12 → 0x00008012.
- SH at 0x06, req_wdata 0xAAAA1234, bus_ready low for 3 cycles → bus_addr = 0x04, bus_be = 1100, bus_wdata = 0x12341234, all stable for 4 cycles; rsp_valid 1 cycle after ready, rsp_rdata = 0.
- LW at 0x02 and SH at 0x01 → bus_req never asserts; rsp_valid at N+1 with rsp_err = 01. DMType 110 → rsp_err = 11.
- TIMEOUT = 4, bus_ready held 0 → bus_req high exactly 4 cycles; rsp_valid, rsp_err = 10, rsp_rdata = 0.
- Reset asserted during BUS wait → bus_req and stall drop the same cycle, req_ready = 1, no rsp_valid. After release, a new LW completes normally.
